// File: rtl/loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_pkg : shared types for cmd_loader_v2 | rev 1.0
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam logic [7:0] REC_LOAD = 8'h01;
    localparam logic [7:0] REC_XFER = 8'h02;
    localparam int ENTRY_AW = 24;

    typedef enum logic [3:0] {
        ST_TYPE    = 4'd0,
        ST_LEN     = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_ADDR_HI = 4'd3,
        ST_DATA    = 4'd4,
        ST_XFER_LO = 4'd5,
        ST_XFER_HI = 4'd6,
        ST_SKIP    = 4'd7,
        ST_DONE    = 4'd8
    } parse_state_t;

    typedef enum logic [1:0] {
        KIND_LOAD = 2'd0,
        KIND_XFER = 2'd1,
        KIND_SKIP = 2'd2
    } rec_kind_t;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } fifo_entry_t;

    // Load length byte also covers the two address bytes; 0/1/2 wrap to 256/257/258.
    function automatic logic [8:0] load_count(input logic [7:0] len);
        return (len < 8'd3) ? {1'b1, len} : ({1'b0, len} - 9'd2);
    endfunction

    function automatic logic [8:0] skip_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_fifo : synchronous FIFO, registered storage, occupancy count | rev 1.0
// ---------------------------------------------------------------------------
module loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_loader_v2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_loader_v2 : TRS-80 /CMD parser / raw loader feeding RAM via FIFO | rev 1.0
// ---------------------------------------------------------------------------
module cmd_loader_v2
    import loader_pkg::*;
#(
    parameter int            AW         = 24,
    parameter int            FIFO_DEPTH = 4,
    parameter logic [7:0]    CMD_INDEX  = 8'd2,
    parameter logic [7:0]    RAW_INDEX  = 8'd1,
    parameter logic [AW-1:0] RAW_BASE   = AW'(24'h010000)
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [7:0]    ioctl_index,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data,
    input  logic          ram_ready,
    output logic          loader_download,
    output logic [15:0]   execute_addr,
    output logic          execute_enable,
    output logic          error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    parse_state_t  state;
    rec_kind_t     kind;
    logic [8:0]    count;
    logic [15:0]   load_addr;
    logic [AW-1:0] raw_ptr;
    logic          active_d;
    logic          loading;
    logic          mode_cmd;
    logic          xfer_seen;

    logic          active;
    logic          start;
    logic          stop;
    logic          take;
    logic          pop;
    logic          push;
    entry_t        push_entry;
    entry_t        pop_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic          trunc;
    logic          finish;

    assign active   = ioctl_download && (ioctl_index == CMD_INDEX || ioctl_index == RAW_INDEX);
    assign start    = active && !active_d;
    assign stop     = !active && active_d;
    // Strobes count only once the start edge has armed the loader.
    assign take     = ioctl_wr && active && active_d && loading;
    assign pop      = ram_wr && ram_ready;
    assign overflow = push && fifo_full && !pop;
    assign trunc    = stop && loading && mode_cmd && (state != ST_TYPE) && (state != ST_DONE);
    assign finish   = loading && !active && fifo_empty;

    always_comb begin
        push            = 1'b0;
        push_entry.addr = '0;
        push_entry.data = ioctl_dout;
        if (take) begin
            if (!mode_cmd) begin
                push            = 1'b1;
                push_entry.addr = raw_ptr;
            end else if (state == ST_DATA) begin
                push            = 1'b1;
                push_entry.addr = AW'(load_addr);
            end
        end
    end

    loader_fifo #(
        .WIDTH (AW + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ram_wr          = !fifo_empty;
    assign ram_addr        = pop_entry.addr;
    assign ram_data        = pop_entry.data;
    assign ioctl_wait      = active && (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign loader_download = loading;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Pretend a download was already seen so a still-high download needs a fresh edge.
            active_d       <= 1'b1;
            loading        <= 1'b0;
            mode_cmd       <= 1'b0;
            state          <= ST_TYPE;
            kind           <= KIND_SKIP;
            count          <= '0;
            load_addr      <= '0;
            raw_ptr        <= RAW_BASE;
            xfer_seen      <= 1'b0;
            execute_addr   <= '0;
            execute_enable <= 1'b0;
            error          <= 1'b0;
        end else begin
            active_d       <= active;
            execute_enable <= 1'b0;

            if (start) begin
                loading   <= 1'b1;
                mode_cmd  <= (ioctl_index == CMD_INDEX);
                state     <= ST_TYPE;
                error     <= 1'b0;
                xfer_seen <= 1'b0;
                raw_ptr   <= RAW_BASE;
            end else if (finish) begin
                loading        <= 1'b0;
                execute_enable <= mode_cmd && xfer_seen && !error && !trunc;
            end

            if (overflow || trunc) error <= 1'b1;

            if (take && !mode_cmd) raw_ptr <= raw_ptr + AW'(1);

            if (take && mode_cmd) begin
                case (state)
                    ST_TYPE: begin
                        kind  <= (ioctl_dout == REC_LOAD) ? KIND_LOAD :
                                 (ioctl_dout == REC_XFER) ? KIND_XFER : KIND_SKIP;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        case (kind)
                            KIND_LOAD: begin
                                count <= load_count(ioctl_dout);
                                state <= ST_ADDR_LO;
                            end
                            KIND_XFER: state <= ST_XFER_LO;
                            default: begin
                                count <= skip_count(ioctl_dout);
                                state <= ST_SKIP;
                            end
                        endcase
                    end
                    ST_ADDR_LO: begin
                        load_addr[7:0] <= ioctl_dout;
                        state          <= ST_ADDR_HI;
                    end
                    ST_ADDR_HI: begin
                        load_addr[15:8] <= ioctl_dout;
                        state           <= ST_DATA;
                    end
                    ST_DATA: begin
                        load_addr <= load_addr + 16'd1;
                        count     <= count - 9'd1;
                        if (count == 9'd1) state <= ST_TYPE;
                    end
                    ST_SKIP: begin
                        count <= count - 9'd1;
                        if (count == 9'd1) state <= ST_TYPE;
                    end
                    ST_XFER_LO: begin
                        execute_addr[7:0] <= ioctl_dout;
                        state             <= ST_XFER_HI;
                    end
                    ST_XFER_HI: begin
                        execute_addr[15:8] <= ioctl_dout;
                        xfer_seen          <= 1'b1;
                        state              <= ST_DONE;
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_TYPE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_loader_v2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_loader_v2 : directed self-checking bench for cmd_loader_v2 | rev 1.0
// ---------------------------------------------------------------------------
module tb_cmd_loader_v2;
    import loader_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        ram_wr;
    logic [23:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_ready;
    logic        loader_download;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic        error;

    int checks = 0;
    int errors = 0;
    fifo_entry_t wq[$];
    int exec_pulses = 0;
    int exec_bad = 0;

    always #5 clk_sys = ~clk_sys;

    cmd_loader_v2 dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_index     (ioctl_index),
        .ioctl_dout      (ioctl_dout),
        .ioctl_wait      (ioctl_wait),
        .ram_wr          (ram_wr),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .ram_ready       (ram_ready),
        .loader_download (loader_download),
        .execute_addr    (execute_addr),
        .execute_enable  (execute_enable),
        .error           (error)
    );

    // Records every accepted RAM write and every start pulse.
    always @(negedge clk_sys) begin
        if (ram_wr && ram_ready) wq.push_back('{addr: ram_addr, data: ram_data});
        if (execute_enable) begin
            exec_pulses++;
            if (loader_download) exec_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_w(input int i);
        if (i < wq.size()) return {wq[i].addr, wq[i].data};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        exec_pulses = 0;
        exec_bad    = 0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic send(input logic [7:0] b, input bit honor_wait);
        int n = 0;
        if (honor_wait) begin
            while (ioctl_wait && n < 500) begin
                tick();
                n++;
            end
            if (n >= 500) check("wait_timeout", 32'(ioctl_wait), 32'h0);
        end
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    task automatic end_dl(input string tag);
        int n = 0;
        ioctl_download = 1'b0;
        while (loader_download && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(loader_download), 32'h0);
        tick();
        tick();
    endtask

    initial begin
        int bad;
        logic [7:0] t1 [11] = '{8'h01, 8'h05, 8'h00, 8'h60, 8'hAA, 8'hBB, 8'hCC,
                                8'h02, 8'h02, 8'h00, 8'h60};
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_dout     = 8'h00;
        ram_ready      = 1'b1;
        repeat (3) tick();
        check("rst_wait",  32'(ioctl_wait), 0);
        check("rst_ramwr", 32'(ram_wr), 0);
        check("rst_addr",  32'(ram_addr), 0);
        check("rst_data",  32'(ram_data), 0);
        check("rst_ld",    32'(loader_download), 0);
        check("rst_xaddr", 32'(execute_addr), 0);
        check("rst_xen",   32'(execute_enable), 0);
        check("rst_err",   32'(error), 0);
        reset_n = 1'b1;
        tick();

        // Ignored index: no ownership, no writes.
        clear_log();
        start_dl(8'h05);
        send(8'h01, 1'b1);
        check("ign_ld",  32'(loader_download), 0);
        check("ign_cnt", wq.size(), 0);
        ioctl_download = 1'b0;
        tick();

        // Basic /CMD load + transfer.
        clear_log();
        start_dl(8'd2);
        check("t1_ld_up", 32'(loader_download), 1);
        foreach (t1[i]) send(t1[i], 1'b1);
        end_dl("t1_ld_down");
        check("t1_cnt",   wq.size(), 3);
        check("t1_w0",    get_w(0), 32'h006000AA);
        check("t1_w1",    get_w(1), 32'h006001BB);
        check("t1_w2",    get_w(2), 32'h006002CC);
        check("t1_xaddr", 32'(execute_addr), 32'h6000);
        check("t1_pulse", exec_pulses, 1);
        check("t1_align", exec_bad, 0);
        check("t1_err",   32'(error), 0);

        // L=0 load at FFFE wraps; comment record skipped; second load lands.
        clear_log();
        start_dl(8'd2);
        send(8'h01, 1'b1); send(8'h00, 1'b1); send(8'hFE, 1'b1); send(8'hFF, 1'b1);
        for (int i = 0; i < 256; i++) send(8'(i), 1'b1);
        send(8'h05, 1'b1); send(8'h03, 1'b1);
        send(8'h41, 1'b1); send(8'h42, 1'b1); send(8'h43, 1'b1);
        send(8'h01, 1'b1); send(8'h03, 1'b1); send(8'h10, 1'b1); send(8'h20, 1'b1);
        send(8'h5A, 1'b1);
        send(8'h02, 1'b1); send(8'h02, 1'b1); send(8'h34, 1'b1); send(8'h12, 1'b1);
        end_dl("t2_ld_down");
        check("t2_cnt", wq.size(), 257);
        check("t2_w0",   get_w(0),   32'h00FFFE00);
        check("t2_w1",   get_w(1),   32'h00FFFF01);
        check("t2_w2",   get_w(2),   32'h00000002);
        check("t2_w255", get_w(255), 32'h0000FDFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (get_w(i) !== {8'h00, 16'(32'hFFFE + i), 8'(i)}) bad++;
        end
        check("t2_all",   bad, 0);
        check("t2_w256",  get_w(256), 32'h0020105A);
        check("t2_xaddr", 32'(execute_addr), 32'h1234);
        check("t2_pulse", exec_pulses, 1);
        check("t2_align", exec_bad, 0);

        // Raw mode with RAM stalled: wait threshold, in-flight slot, overflow.
        clear_log();
        ram_ready = 1'b0;
        start_dl(8'd1);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        check("t3_wait2", 32'(ioctl_wait), 0);
        send(8'h33, 1'b1);
        check("t3_wait3", 32'(ioctl_wait), 1);
        send(8'h44, 1'b0);
        check("t3_noerr", 32'(error), 0);
        check("t3_head",  {ram_addr, ram_data}, 32'h01000011);
        check("t3_ramwr", 32'(ram_wr), 1);
        send(8'h55, 1'b0);
        check("t3_ovf",   32'(error), 1);
        repeat (2) tick();
        check("t3_stall", wq.size(), 0);
        ram_ready = 1'b1;
        end_dl("t3_ld_down");
        check("t3_cnt", wq.size(), 4);
        check("t3_w0",  get_w(0), 32'h01000011);
        check("t3_w1",  get_w(1), 32'h01000122);
        check("t3_w2",  get_w(2), 32'h01000233);
        check("t3_w3",  get_w(3), 32'h01000344);
        check("t3_pulse", exec_pulses, 0);

        // Truncated load record.
        clear_log();
        start_dl(8'd2);
        check("t4_errclr", 32'(error), 0);
        send(8'h01, 1'b1); send(8'h10, 1'b1); send(8'h00, 1'b1);
        send(8'h70, 1'b1); send(8'h11, 1'b1);
        end_dl("t4_ld_down");
        check("t4_err",   32'(error), 1);
        check("t4_cnt",   wq.size(), 1);
        check("t4_w0",    get_w(0), 32'h00700011);
        check("t4_pulse", exec_pulses, 0);

        // Reset in the middle of a data record.
        clear_log();
        ram_ready = 1'b0;
        start_dl(8'd2);
        send(8'h01, 1'b1); send(8'h05, 1'b1); send(8'h00, 1'b1);
        send(8'h80, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1);
        check("t5_pending", 32'(ram_wr), 1);
        reset_n = 1'b0;
        tick();
        check("t5_ramwr", 32'(ram_wr), 0);
        check("t5_ld",    32'(loader_download), 0);
        check("t5_err",   32'(error), 0);
        reset_n = 1'b1;
        tick();
        send(8'h03, 1'b1);
        ram_ready = 1'b1;
        repeat (3) tick();
        check("t5_nowr",  wq.size(), 0);
        check("t5_ld_lo", 32'(loader_download), 0);
        ioctl_download = 1'b0;
        repeat (2) tick();
        start_dl(8'd2);
        send(8'h01, 1'b1); send(8'h03, 1'b1); send(8'h00, 1'b1); send(8'h90, 1'b1);
        send(8'h77, 1'b1);
        send(8'h02, 1'b1); send(8'h02, 1'b1); send(8'h00, 1'b1); send(8'h90, 1'b1);
        end_dl("t5_ld_down");
        check("t5_cnt",   wq.size(), 1);
        check("t5_w0",    get_w(0), 32'h00900077);
        check("t5_xaddr", 32'(execute_addr), 32'h9000);
        check("t5_pulse", exec_pulses, 1);
        check("t5_err2",  32'(error), 0);
        check("t5_align", exec_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
